// File: rtl/aether_cmd_sequencer.sv
// Aether command sequencer: queues host commands, issues them one at a time on cmd_o,
// waits for the engine interrupt on blocking instructions and captures response data.
module aether_cmd_sequencer #(
    parameter int unsigned CmdFifoDepth  = 16,
    parameter int unsigned RespFifoDepth = 8,
    parameter logic [3:0]  NopInstr      = 4'h0,
    parameter logic [15:0] BlockingMask  = 16'hFFFE,
    parameter logic [15:0] CaptureMask   = 16'h0004,
    parameter int unsigned WaitTimeout   = 1_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [23:0]                   host_cmd_i,
    input  logic                          host_cmd_valid_i,
    output logic                          host_cmd_ready_o,
    output logic [15:0]                   resp_data_o,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [23:0]                   cmd_o,
    input  logic [15:0]                   engine_data_i,
    input  logic                          engine_interrupt_i,
    output logic                          busy_o,
    output logic                          timeout_o,
    output logic [$clog2(CmdFifoDepth):0] cmd_count_o
);

    localparam int unsigned CmdAw    = $clog2(CmdFifoDepth);
    localparam int unsigned CmdPtrW  = CmdAw + 1;
    localparam int unsigned RespAw   = $clog2(RespFifoDepth);
    localparam int unsigned RespPtrW = RespAw + 1;
    localparam int unsigned CntW     = $clog2(WaitTimeout);

    localparam logic [CmdPtrW-1:0]  CmdFull  = CmdPtrW'(CmdFifoDepth);
    localparam logic [RespPtrW-1:0] RespFull = RespPtrW'(RespFifoDepth);
    localparam logic [CntW-1:0]     CntLast  = CntW'(WaitTimeout - 1);
    localparam logic [23:0]         NopCmd   = {NopInstr, 20'h0};

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStall} state_e;

    state_e state_q, state_d;

    // ---------------------------------------------------------------- command FIFO
    logic [23:0]        cmd_mem_q [CmdFifoDepth];
    logic [CmdPtrW-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CmdPtrW-1:0] cmd_count;
    logic               cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [23:0]        cmd_head;

    assign cmd_count        = cmd_wr_ptr_q - cmd_rd_ptr_q;
    assign cmd_full         = (cmd_count == CmdFull);
    assign cmd_empty        = (cmd_count == '0);
    assign cmd_head         = cmd_mem_q[cmd_rd_ptr_q[CmdAw-1:0]];
    assign host_cmd_ready_o = ~rst_i & ~cmd_full;
    assign cmd_push         = host_cmd_valid_i & host_cmd_ready_o;
    assign cmd_count_o      = cmd_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr_q <= cmd_wr_ptr_q + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr_q <= cmd_rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wr_ptr_q[CmdAw-1:0]] <= host_cmd_i;
        end
    end

    // --------------------------------------------------------------- response FIFO
    logic [15:0]         resp_mem_q [RespFifoDepth];
    logic [RespPtrW-1:0] resp_wr_ptr_q, resp_rd_ptr_q;
    logic [RespPtrW-1:0] resp_count;
    logic                resp_full, resp_push, resp_pop, resp_can_push;
    logic [15:0]         resp_wdata;

    assign resp_count   = resp_wr_ptr_q - resp_rd_ptr_q;
    assign resp_full    = (resp_count == RespFull);
    assign resp_valid_o = (resp_count != '0);
    assign resp_data_o  = resp_mem_q[resp_rd_ptr_q[RespAw-1:0]];
    assign resp_pop     = resp_valid_o & resp_ready_i;
    // A host pop in the same cycle frees the slot the push needs.
    assign resp_can_push = ~resp_full | resp_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_wr_ptr_q <= '0;
            resp_rd_ptr_q <= '0;
        end else begin
            if (resp_push) begin
                resp_wr_ptr_q <= resp_wr_ptr_q + 1'b1;
            end
            if (resp_pop) begin
                resp_rd_ptr_q <= resp_rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (resp_push) begin
            resp_mem_q[resp_wr_ptr_q[RespAw-1:0]] <= resp_wdata;
        end
    end

    // ------------------------------------------------------------ sequencer state
    logic [23:0]     cmd_q;
    logic [3:0]      cur_instr_q;
    logic            irq_q;
    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_q;
    logic [15:0]     stall_data_q;

    logic irq_edge, wait_expired, cur_blocking, cur_capture;
    logic stall_load, timeout_set, timeout_clr;

    assign irq_edge     = engine_interrupt_i & ~irq_q;
    assign wait_expired = (wait_cnt_q == CntLast);
    assign cur_blocking = BlockingMask[cur_instr_q];
    assign cur_capture  = CaptureMask[cur_instr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!cmd_empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = cur_blocking ? StWait : StIdle;
            end
            StWait: begin
                // An interrupt edge takes priority over an expiring timeout.
                if (irq_edge) begin
                    state_d = (cur_capture && !resp_can_push) ? StStall : StIdle;
                end else if (wait_expired) begin
                    state_d = StIdle;
                end
            end
            StStall: begin
                if (resp_can_push) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_pop     = 1'b0;
        resp_push   = 1'b0;
        resp_wdata  = engine_data_i;
        stall_load  = 1'b0;
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_pop = ~cmd_empty;
            end
            StIssue: begin
                timeout_clr = cur_blocking;
            end
            StWait: begin
                if (irq_edge) begin
                    if (cur_capture) begin
                        resp_push  = resp_can_push;
                        stall_load = ~resp_can_push;
                    end
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                end
            end
            StStall: begin
                resp_wdata = stall_data_q;
                resp_push  = resp_can_push;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q        <= NopCmd;
            cur_instr_q  <= NopInstr;
            irq_q        <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            stall_data_q <= '0;
        end else begin
            irq_q <= engine_interrupt_i;
            // cmd_o carries a command for exactly the issue cycle, NOP otherwise.
            cmd_q <= cmd_pop ? cmd_head : NopCmd;
            if (cmd_pop) begin
                cur_instr_q <= cmd_head[23:20];
            end
            if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (timeout_clr) begin
                timeout_q <= 1'b0;
            end
            if (stall_load) begin
                stall_data_q <= engine_data_i;
            end
        end
    end

    assign cmd_o     = cmd_q;
    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != StIdle) | ~cmd_empty;

endmodule

// File: tb/tb_aether_cmd_sequencer.sv
// Bench for aether_cmd_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a queue-based job model.
module tb_aether_cmd_sequencer;

    localparam int unsigned CmdDepth  = 16;
    localparam int unsigned RespDepth = 8;
    localparam logic [15:0] BlockMask = 16'hFFFC;
    localparam logic [15:0] CaptMask  = 16'h0004;
    localparam int unsigned Timeout   = 50;
    localparam logic [23:0] NopCmd    = 24'h000000;

    logic        clk = 1'b0;
    logic        rst, host_cmd_valid, host_cmd_ready, resp_valid, resp_ready;
    logic        engine_irq, busy, timeout;
    logic [23:0] host_cmd, cmd;
    logic [15:0] resp_data, engine_data;
    logic [4:0]  cmd_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    aether_cmd_sequencer #(
        .CmdFifoDepth (CmdDepth),
        .RespFifoDepth(RespDepth),
        .NopInstr     (4'h0),
        .BlockingMask (BlockMask),
        .CaptureMask  (CaptMask),
        .WaitTimeout  (Timeout)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .host_cmd_i        (host_cmd),
        .host_cmd_valid_i  (host_cmd_valid),
        .host_cmd_ready_o  (host_cmd_ready),
        .resp_data_o       (resp_data),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .cmd_o             (cmd),
        .engine_data_i     (engine_data),
        .engine_interrupt_i(engine_irq),
        .busy_o            (busy),
        .timeout_o         (timeout),
        .cmd_count_o       (cmd_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Job model: one job in flight at a time, walking issue -> wait -> (stall) -> done.
    logic [23:0] mq[$];
    logic [15:0] rq[$];
    logic [23:0] m_cmd = NopCmd;
    bit          m_job, m_issuing, m_waiting, m_stalled, m_timeout, m_prev_irq;
    int          m_waited;
    logic [3:0]  m_instr;
    logic [15:0] m_held;

    always @(posedge clk) begin
        bit          edge_seen, accept, room;
        logic [23:0] nxt;
        if (rst) begin
            mq.delete();
            rq.delete();
            m_cmd      = NopCmd;
            m_job      = 1'b0;
            m_issuing  = 1'b0;
            m_waiting  = 1'b0;
            m_stalled  = 1'b0;
            m_timeout  = 1'b0;
            m_prev_irq = 1'b0;
            m_waited   = 0;
        end else begin
            edge_seen  = engine_irq && !m_prev_irq;
            m_prev_irq = engine_irq;
            accept     = host_cmd_valid && (mq.size() < CmdDepth);
            if (rq.size() > 0 && resp_ready) void'(rq.pop_front());
            room = (rq.size() < RespDepth);
            nxt  = NopCmd;
            if (!m_job) begin
                if (mq.size() > 0) begin
                    nxt       = mq.pop_front();
                    m_instr   = nxt[23:20];
                    m_job     = 1'b1;
                    m_issuing = 1'b1;
                end
            end else if (m_issuing) begin
                m_issuing = 1'b0;
                if (BlockMask[m_instr]) begin
                    m_waiting = 1'b1;
                    m_waited  = 0;
                    m_timeout = 1'b0;
                end else begin
                    m_job = 1'b0;
                end
            end else if (m_waiting) begin
                if (edge_seen) begin
                    m_waiting = 1'b0;
                    if (CaptMask[m_instr] && !room) begin
                        m_stalled = 1'b1;
                        m_held    = engine_data;
                    end else begin
                        if (CaptMask[m_instr]) rq.push_back(engine_data);
                        m_job = 1'b0;
                    end
                end else begin
                    m_waited++;
                    if (m_waited == Timeout) begin
                        m_timeout = 1'b1;
                        m_waiting = 1'b0;
                        m_job     = 1'b0;
                    end
                end
            end else if (m_stalled) begin
                if (room) begin
                    rq.push_back(m_held);
                    m_stalled = 1'b0;
                    m_job     = 1'b0;
                end
            end
            if (accept) mq.push_back(host_cmd);
            m_cmd = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cmd", 32'(cmd), 32'(m_cmd));
            check("m_ready", 32'(host_cmd_ready), 32'(!rst && mq.size() < CmdDepth));
            check("m_count", 32'(cmd_count), 32'(mq.size()));
            check("m_busy", 32'(busy), 32'(m_job || mq.size() > 0));
            check("m_timeout", 32'(timeout), 32'(m_timeout));
            check("m_resp_valid", 32'(resp_valid), 32'(rq.size() > 0));
            if (rq.size() > 0) check("m_resp_data", 32'(resp_data), 32'(rq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] c);
        host_cmd       = c;
        host_cmd_valid = 1'b1;
        tick();
        host_cmd_valid = 1'b0;
    endtask

    task automatic capture(input logic [15:0] d);
        push(24'h200000 | 24'(d));
        tick();
        tick();
        engine_irq  = 1'b1;
        engine_data = d;
        tick();
        engine_irq = 1'b0;
        tick();
    endtask

    initial begin
        int          got;
        logic [31:0] r;
        logic [3:0]  ins;
        rst            = 1'b1;
        host_cmd       = '0;
        host_cmd_valid = 1'b0;
        resp_ready     = 1'b0;
        engine_data    = '0;
        engine_irq     = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_ready", 32'(host_cmd_ready), 0);
        check("rst_cmd", 32'(cmd), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(cmd_count), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(host_cmd_ready), 1);

        // Non-blocking command latency.
        push(24'h100005);
        check("lat_n1_cmd", 32'(cmd), 0);
        check("lat_n1_count", 32'(cmd_count), 1);
        tick();
        check("lat_n2_cmd", 32'(cmd), 32'h100005);
        tick();
        check("lat_n3_cmd", 32'(cmd), 0);
        check("lat_n3_busy", 32'(busy), 0);

        // Blocking capture.
        push(24'h2300AA);
        tick();
        check("blk_issue", 32'(cmd), 32'h2300AA);
        repeat (9) tick();
        engine_irq  = 1'b1;
        engine_data = 16'hBEEF;
        tick();
        check("cap_valid", 32'(resp_valid), 1);
        check("cap_data", 32'(resp_data), 32'hBEEF);
        engine_irq = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("cap_popped", 32'(resp_valid), 0);

        // Fill the command FIFO behind a waiting blocking command.
        push(24'h300001);
        for (int i = 0; i < 16; i++) push(24'h100100 + 24'(i));
        check("full_ready", 32'(host_cmd_ready), 0);
        check("full_count", 32'(cmd_count), 16);
        push(24'h10FFFF);
        check("full_reject", 32'(cmd_count), 16);
        engine_irq = 1'b1;
        tick();
        engine_irq = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            tick();
            if (cmd !== NopCmd) begin
                check("drain_order", 32'(cmd), 32'h100100 + 32'(got));
                got++;
            end
        end
        check("drain_count", got, 16);

        // Timeout after 50 WAIT cycles, then next command, then clear on blocking issue.
        push(24'h300002);
        push(24'h100003);
        repeat (50) tick();
        check("to_before", 32'(timeout), 0);
        tick();
        check("to_set", 32'(timeout), 1);
        check("to_cmd_nop", 32'(cmd), 0);
        tick();
        check("to_next_cmd", 32'(cmd), 32'h100003);
        push(24'h300004);
        check("to_sticky", 32'(timeout), 1);
        tick();
        check("to_blk_issue", 32'(cmd), 32'h300004);
        check("to_still_set", 32'(timeout), 1);
        tick();
        check("to_cleared", 32'(timeout), 0);
        engine_irq = 1'b1;
        tick();
        engine_irq = 1'b0;
        tick();

        // Response FIFO full -> STALL -> single host pop releases it.
        for (int i = 0; i < 8; i++) capture(16'hD000 + 16'(i));
        push(24'h200008);
        tick();
        tick();
        engine_irq  = 1'b1;
        engine_data = 16'hD008;
        tick();
        engine_irq  = 1'b0;
        engine_data = 16'h0000;
        tick();
        check("stall_busy", 32'(busy), 1);
        check("stall_head", 32'(resp_data), 32'hD000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("stall_released", 32'(busy), 0);
        resp_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("stall_drain", 32'(resp_data), 32'hD000 + 32'(i));
            tick();
        end
        resp_ready = 1'b0;
        check("stall_empty", 32'(resp_valid), 0);

        // Reset in the middle of a WAIT.
        push(24'h300007);
        push(24'h100008);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_cmd", 32'(cmd), 0);
        check("rstw_count", 32'(cmd_count), 0);
        check("rstw_busy", 32'(busy), 0);
        engine_irq = 1'b1;
        tick();
        engine_irq = 1'b0;
        tick();
        check("rstw_resp", 32'(resp_valid), 0);
        check("rstw_busy2", 32'(busy), 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 599) == 0);
            host_cmd_valid = ($urandom_range(0, 1) == 1);
            r              = $urandom();
            ins = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                               : 4'($urandom_range(0, 15));
            host_cmd    = {ins, r[19:0]};
            resp_ready  = ($urandom_range(0, 3) == 0);
            engine_data = 16'($urandom());
            if ($urandom_range(0, 9) == 0) engine_irq = ~engine_irq;
            tick();
        end
        rst            = 1'b0;
        host_cmd_valid = 1'b0;
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
